env_reader: RTL and testbench

- Raster-order reader for the environment grid. It is the read-side counterpart of the simState_controller write sweep.
- On `start`, it walks every cell (0,0)..(X_MAX,Y_MAX) through the environment lookup port and captures sugar/signal for each cell.
- Each cell goes out as a record on a valid/ready stream, which feeds Nios telemetry/save. Running sugar and signal statistics are kept alongside.
- Owns the lookup address only while `busy`; the lookup mux in the top level selects this block when `busy`=1.

---
 rtl/env_reader.sv | 184 ++++++++++++++++++
 tb/tb_env_reader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/env_reader.sv
// env_reader: raster-order reader for the environment grid.
// On start it walks (0,0)..(X_MAX,Y_MAX) through the environment lookup
// port. Each cell goes out as one record on a valid/ready stream. The
// block keeps running sugar and signal statistics over the accepted
// records.
// Ports:
//   Clk, Reset_n            - clock, asynchronous active-low reset
//   start, abort            - begin a sweep / cancel a sweep in progress
//   lookup_X/Y              - environment read address (meaningful while busy)
//   lookup_sugar/signal     - lookup data, READ_LAT clocks after the address
//   out_valid/ready         - record handshake
//   out_x/y/sugar/signal    - record payload
//   out_last                - record is cell (X_MAX,Y_MAX)
//   busy, done              - sweep in progress / one-cycle completion pulse
//   sugar_count, signal_max - statistics over records handed off this sweep
module env_reader #(
    parameter int X_bits      = 8,
    parameter int Y_bits      = 7,
    parameter int SIGNAL_bits = 4,
    parameter int X_MAX       = 159,
    parameter int Y_MAX       = 119,
    parameter int READ_LAT    = 1     // 1..3
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [X_bits-1:0]      lookup_X,
    output logic [Y_bits-1:0]      lookup_Y,
    input  logic                   lookup_sugar,
    input  logic [SIGNAL_bits-1:0] lookup_signal,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [X_bits-1:0]      out_x,
    output logic [Y_bits-1:0]      out_y,
    output logic                   out_sugar,
    output logic [SIGNAL_bits-1:0] out_signal,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            sugar_count,
    output logic [SIGNAL_bits-1:0] signal_max
);

    localparam int WAIT_W = 2;

    typedef enum logic [1:0] {IDLE, READ, PRESENT, DONE} state_e;

    state_e                 state_q, state_d;
    logic [X_bits-1:0]      x_q, x_d;
    logic [Y_bits-1:0]      y_q, y_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [X_bits-1:0]      out_x_q, out_x_d;
    logic [Y_bits-1:0]      out_y_q, out_y_d;
    logic                   out_sugar_q, out_sugar_d;
    logic [SIGNAL_bits-1:0] out_signal_q, out_signal_d;
    logic                   out_last_q, out_last_d;
    logic [15:0]            sugar_count_q, sugar_count_d;
    logic [SIGNAL_bits-1:0] signal_max_q, signal_max_d;

    logic capture, handshake, x_end, y_end;

    // The wait counter starts at 0 for the first cell and at 1 after an
    // advance. The first cell therefore spends one extra clock in READ, so
    // its address has been stable for READ_LAT clocks before capture.
    assign capture   = (state_q == READ) && (wait_q == WAIT_W'(READ_LAT));
    assign handshake = (state_q == PRESENT) && out_ready;
    assign x_end     = (x_q == X_bits'(X_MAX));
    assign y_end     = (y_q == Y_bits'(Y_MAX));

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state; abort outranks everything outside IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (abort) state_d = IDLE;
                     else if (capture) state_d = PRESENT;
            PRESENT: if (abort) state_d = IDLE;
                     else if (handshake) state_d = out_last_q ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy      = (state_q == READ) || (state_q == PRESENT);
        done      = (state_q == DONE);
        out_valid = (state_q == PRESENT);
    end

    // Datapath next values
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        wait_d        = wait_q;
        out_x_d       = out_x_q;
        out_y_d       = out_y_q;
        out_sugar_d   = out_sugar_q;
        out_signal_d  = out_signal_q;
        out_last_d    = out_last_q;
        sugar_count_d = sugar_count_q;
        signal_max_d  = signal_max_q;
        case (state_q)
            IDLE: if (start) begin
                x_d           = '0;
                y_d           = '0;
                wait_d        = '0;
                sugar_count_d = '0;
                signal_max_d  = '0;
            end
            READ: if (!abort) begin
                if (capture) begin
                    out_x_d      = x_q;
                    out_y_d      = y_q;
                    out_sugar_d  = lookup_sugar;
                    out_signal_d = lookup_signal;
                    out_last_d   = x_end && y_end;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            PRESENT: if (!abort && handshake) begin
                if (sugar_count_q != 16'hFFFF)
                    sugar_count_d = sugar_count_q + 16'(out_sugar_q);
                if (out_signal_q > signal_max_q)
                    signal_max_d = out_signal_q;
                if (!out_last_q) begin
                    wait_d = WAIT_W'(1);
                    if (x_end) begin
                        x_d = '0;
                        y_d = y_q + Y_bits'(1);
                    end else begin
                        x_d = x_q + X_bits'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_q           <= '0;
            y_q           <= '0;
            wait_q        <= '0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            out_sugar_q   <= 1'b0;
            out_signal_q  <= '0;
            out_last_q    <= 1'b0;
            sugar_count_q <= '0;
            signal_max_q  <= '0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            wait_q        <= wait_d;
            out_x_q       <= out_x_d;
            out_y_q       <= out_y_d;
            out_sugar_q   <= out_sugar_d;
            out_signal_q  <= out_signal_d;
            out_last_q    <= out_last_d;
            sugar_count_q <= sugar_count_d;
            signal_max_q  <= signal_max_d;
        end
    end

    assign lookup_X    = x_q;
    assign lookup_Y    = y_q;
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;
    assign out_sugar   = out_sugar_q;
    assign out_signal  = out_signal_q;
    assign out_last    = out_last_q;
    assign sugar_count = sugar_count_q;
    assign signal_max  = signal_max_q;

endmodule

// File: tb/tb_env_reader.sv
// Bench for env_reader on a 4x3 grid. Two copies run side by side on the
// same stimulus, one with READ_LAT=1 and one with READ_LAT=3. Each copy
// sees an environment returning sugar=(x==y) and signal=x+y.
module tb_env_reader;

    localparam int NC = 12;   // cells in a 4x3 grid

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b1;
    logic [1:0][7:0]  lx, ox;
    logic [1:0][6:0]  ly, oy;
    logic [1:0][3:0]  lsig, osig, smax;
    logic [1:0][15:0] scnt;
    logic [1:0]       lsug, osug, ov, olast, bsy, dn;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int LAT = (g == 0) ? 1 : 3;
        env_reader #(.X_MAX(3), .Y_MAX(2), .READ_LAT(LAT)) dut (
            .Clk(clk), .Reset_n(rst_n), .start(start), .abort(abort),
            .lookup_X(lx[g]), .lookup_Y(ly[g]),
            .lookup_sugar(lsug[g]), .lookup_signal(lsig[g]),
            .out_valid(ov[g]), .out_ready(ready),
            .out_x(ox[g]), .out_y(oy[g]), .out_sugar(osug[g]),
            .out_signal(osig[g]), .out_last(olast[g]),
            .busy(bsy[g]), .done(dn[g]),
            .sugar_count(scnt[g]), .signal_max(smax[g]));

        // Environment: the data seen at a capture edge belongs to the address
        // that was presented READ_LAT-1 clocks earlier.
        logic [7:0] dx1, dx2;
        logic [6:0] dy1, dy2;
        always @(posedge clk) begin
            dx1 <= lx[g]; dx2 <= dx1;
            dy1 <= ly[g]; dy2 <= dy1;
        end
        wire [7:0] ax = (LAT == 1) ? lx[g] : dx2;
        wire [7:0] ay = (LAT == 1) ? {1'b0, ly[g]} : {1'b0, dy2};
        assign lsug[g] = (ax == ay);
        assign lsig[g] = 4'(ax + ay);
    end

    function automatic int lat(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    // Reference model: which cell is due, when it becomes visible, and the
    // statistics over accepted cells.
    bit mb[2], md[2];
    int midx[2], mcnt[2], mneed[2], msc[2], msm[2];

    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                mb[g] = 0; md[g] = 0; midx[g] = 0; mcnt[g] = 0;
                mneed[g] = 0; msc[g] = 0; msm[g] = 0;
            end else if (!mb[g] && !md[g]) begin
                if (start) begin
                    mb[g] = 1; midx[g] = 0; mcnt[g] = 0; mneed[g] = lat(g) + 1;
                    msc[g] = 0; msm[g] = 0;
                end
            end else if (mb[g]) begin
                if (abort) begin
                    mb[g] = 0;
                end else if (mcnt[g] >= mneed[g] && ready) begin
                    if ((midx[g] % 4) == (midx[g] / 4) && msc[g] < 65535) msc[g]++;
                    if ((midx[g] % 4) + (midx[g] / 4) > msm[g]) msm[g] = (midx[g] % 4) + (midx[g] / 4);
                    if (midx[g] == NC - 1) begin
                        mb[g] = 0; md[g] = 1;
                    end else begin
                        midx[g]++; mcnt[g] = 0; mneed[g] = lat(g);
                    end
                end else begin
                    mcnt[g]++;
                end
            end else begin
                md[g] = 0;
            end
        end
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int tests = 0, errs = 0;
    int phase = 0, start_cyc = 0, tmo = 0, tmo_seen = 0;
    bit seen[2];

    task automatic chk(input string nm, input int g, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, g, act, exp);
        end
    endtask

    // Compare process
    initial forever begin
        @(negedge clk or negedge rst_n);
        #1;
        if (tmo != tmo_seen) begin
            chk("wait_timeout", 0, tmo, 0);
            tmo_seen = tmo;
        end
        if (cyc == start_cyc && start_cyc > 0 && rst_n) begin
            for (int g = 0; g < 2; g++) begin
                chk("start_clears_sugar_count", g, int'(scnt[g]), 0);
                chk("start_clears_signal_max", g, int'(smax[g]), 0);
            end
        end
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                chk("rst_lookup_X", g, int'(lx[g]), 0);
                chk("rst_lookup_Y", g, int'(ly[g]), 0);
                chk("rst_out_valid", g, int'(ov[g]), 0);
                chk("rst_out_x", g, int'(ox[g]), 0);
                chk("rst_out_y", g, int'(oy[g]), 0);
                chk("rst_out_sugar", g, int'(osug[g]), 0);
                chk("rst_out_signal", g, int'(osig[g]), 0);
                chk("rst_out_last", g, int'(olast[g]), 0);
                chk("rst_busy", g, int'(bsy[g]), 0);
                chk("rst_done", g, int'(dn[g]), 0);
                chk("rst_sugar_count", g, int'(scnt[g]), 0);
                chk("rst_signal_max", g, int'(smax[g]), 0);
            end else begin
                int cx, cy;
                bit ev;
                cx = midx[g] % 4;
                cy = midx[g] / 4;
                ev = mb[g] && (mcnt[g] >= mneed[g]);
                chk("busy", g, int'(bsy[g]), int'(mb[g]));
                chk("done", g, int'(dn[g]), int'(md[g]));
                chk("out_valid", g, int'(ov[g]), int'(ev));
                chk("sugar_count", g, int'(scnt[g]), msc[g]);
                chk("signal_max", g, int'(smax[g]), msm[g]);
                if (ev) begin
                    chk("out_x", g, int'(ox[g]), cx);
                    chk("out_y", g, int'(oy[g]), cy);
                    chk("out_sugar", g, int'(osug[g]), (cx == cy) ? 1 : 0);
                    chk("out_signal", g, int'(osig[g]), cx + cy);
                    chk("out_last", g, int'(olast[g]), (midx[g] == NC - 1) ? 1 : 0);
                end
                if (mb[g]) begin
                    chk("lookup_X", g, int'(lx[g]), cx);
                    chk("lookup_Y", g, int'(ly[g]), cy);
                end
                // Hand-computed anchors
                if (!bsy[g]) seen[g] = 0;
                else if (ov[g] && !seen[g]) begin
                    seen[g] = 1;
                    chk("first_valid_latency", g, cyc - start_cyc, (g == 0) ? 2 : 4);
                end
                if (dn[g] && (phase == 1 || phase == 2 || phase == 3 || phase == 7)) begin
                    chk("sweep_sugar_count", g, int'(scnt[g]), 3);
                    chk("sweep_signal_max", g, int'(smax[g]), 5);
                end
                if (phase == 2 && !ready && g == 0) begin
                    chk("stall_out_valid", g, int'(ov[g]), 1);
                    chk("stall_out_x", g, int'(ox[g]), 2);
                    chk("stall_out_y", g, int'(oy[g]), 1);
                    chk("stall_out_signal", g, int'(osig[g]), 3);
                    chk("stall_sugar_count", g, int'(scnt[g]), 2);
                    chk("stall_signal_max", g, int'(smax[g]), 3);
                end
                if (phase == 5 && g == 0) begin
                    chk("abort_busy", g, int'(bsy[g]), 0);
                    chk("abort_out_valid", g, int'(ov[g]), 0);
                    chk("abort_sugar_count", g, int'(scnt[g]), 1);
                end
            end
        end
    end

    task automatic do_start(input int ph);
        @(negedge clk); #2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        phase = ph;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while ((bsy != 2'b00 || dn != 2'b00) && n < 400);
        if (n >= 400) tmo++;
    endtask

    task automatic wait_rec(input int x, input int y);
        int n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while (!(ov[0] && int'(ox[0]) == x && int'(oy[0]) == y) && n < 200);
        if (n >= 200) tmo++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        do_start(1);                 // plain sweep
        wait_idle();

        do_start(2);                 // consumer stall on (2,1)
        wait_rec(2, 1);
        ready = 1'b0;
        repeat (5) @(negedge clk);
        #2 ready = 1'b1;
        wait_idle();

        do_start(3);                 // start while busy is ignored
        repeat (6) @(negedge clk);
        #2 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle();

        do_start(4);                 // abort during (1,1)
        wait_rec(1, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        phase = 5;
        @(negedge clk); #2;
        phase = 6;
        wait_idle();

        do_start(6);                 // async reset while presenting (0,1)
        wait_rec(0, 1);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        do_start(7);                 // full sweep after reset
        wait_idle();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
